exa_crosb_input_arbiter_with_vcs: RTL

//  Input-side arbiter of the ExaNet crossbar, one instance per input port.
//  - Raises per-VC/prio requests towards every output arbiter that has an eligible queue head.
//  - Accepts at most one grant and answers it with CTS to the granting output.
//  - Pops the chosen queue until its last flit, while declined outputs see CTS low and recycle.

---
 rtl/exa_crosb_pkg.sv | 20 ++
 rtl/exa_iarb_vc_rr_pick.sv | 27 ++
 rtl/exa_crosb_input_arbiter_with_vcs.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/exa_crosb_pkg.sv
// Shared types and helpers for the ExaNet crossbar input arbiter.
package exa_crosb_pkg;

   localparam int unsigned PRIO_NUM   = 2;
   localparam int unsigned VC_NUM     = 2;
   localparam int unsigned OUTPUT_NUM = 4;
   localparam int unsigned Q          = PRIO_NUM * VC_NUM;

   typedef enum logic {
      IDLE,
      STREAM
   } state_e;

   function automatic int unsigned qidx(input int unsigned prio,
                                        input int unsigned vc,
                                        input int unsigned vcn = VC_NUM);
      return prio * vcn + vc;
   endfunction

endpackage

// File: rtl/exa_iarb_vc_rr_pick.sv
// Round-robin pick over the VCs of one priority level, starting at ptr_i.
module exa_iarb_vc_rr_pick #(
   parameter int unsigned vc_num = 2
) (
   input  logic [vc_num-1:0]                                req_i,
   input  logic [((vc_num > 1) ? $clog2(vc_num) : 1)-1:0]   ptr_i,
   output logic                                             valid_o,
   output logic [((vc_num > 1) ? $clog2(vc_num) : 1)-1:0]   idx_o
);

   localparam int unsigned PW = (vc_num > 1) ? $clog2(vc_num) : 1;

   always_comb begin
      int unsigned cand;
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      for (int unsigned i = 0; i < vc_num; i++) begin
         cand = (32'(ptr_i) + i) % vc_num;
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/exa_crosb_input_arbiter_with_vcs.sv
// ExaNet crossbar input-side arbiter: per-VC/prio requests, single grant accept, packet streaming.
// Optional per-queue downstream credit gating is enabled with `define EXA_IARB_CREDIT_EN.
module exa_crosb_input_arbiter_with_vcs
   import exa_crosb_pkg::*;
#(
   parameter int unsigned prio_num   = PRIO_NUM,
   parameter int unsigned vc_num     = VC_NUM,
   parameter int unsigned output_num = OUTPUT_NUM,
   parameter int unsigned CREDIT_MAX = 8
) (
   input  logic                                                   clk,
   input  logic                                                   resetn,
   input  logic [vc_num*prio_num-1:0]                             i_head_valid,
   input  logic [vc_num*prio_num-1:0][$clog2(output_num)-1:0]     i_head_dest,
   input  logic [vc_num*prio_num-1:0]                             i_head_last,
   input  logic [output_num-1:0]                                  i_grant,
   input  logic [vc_num*prio_num-1:0]                             i_credit_return,
   output logic [output_num-1:0][vc_num*prio_num-1:0]             o_request,
   output logic [output_num-1:0]                                  o_cts,
   output logic [vc_num*prio_num-1:0]                             o_pop,
   output logic                                                   o_last,
   output logic [$clog2(output_num)-1:0]                          o_out_sel,
   output logic                                                   o_busy
);

   localparam int unsigned NQ   = vc_num * prio_num;
   localparam int unsigned OW   = $clog2(output_num);
   localparam int unsigned OPOW = 1 << OW;
   localparam int unsigned QW   = (NQ > 1) ? $clog2(NQ) : 1;
   localparam int unsigned PW   = (vc_num > 1) ? $clog2(vc_num) : 1;

   state_e                      state_q, state_d;
   logic [QW-1:0]               q_sel_q, q_sel_d;
   logic [OW-1:0]               out_sel_q, out_sel_d;
   logic [prio_num-1:0][PW-1:0] ptr_q, ptr_d;
   logic [NQ-1:0]               credit_ok;
   logic [NQ-1:0]               elig;
   logic [OPOW-1:0]             grant_ext;
   logic [prio_num-1:0]         pick_valid;
   logic [prio_num-1:0][PW-1:0] pick_vc;

`ifdef EXA_IARB_CREDIT_EN
   localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

   logic [NQ-1:0][CW-1:0] credit_q, credit_d;

   always_comb begin
      credit_d = credit_q;
      for (int unsigned q = 0; q < NQ; q++) begin
         credit_ok[q] = (credit_q[q] != '0);
         case ({o_pop[q], i_credit_return[q]})
            2'b10:   credit_d[q] = credit_q[q] - 1'b1;
            2'b01:   if (credit_q[q] != CW'(CREDIT_MAX)) credit_d[q] = credit_q[q] + 1'b1;
            default: credit_d[q] = credit_q[q];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned q = 0; q < NQ; q++) credit_q[q] <= CW'(CREDIT_MAX);
      end else begin
         credit_q <= credit_d;
      end
   end

`ifndef SYNTHESIS
   // A return on a full counter means the downstream buffer accounting is broken.
   always_ff @(posedge clk) begin
      if (resetn) begin
         for (int unsigned q = 0; q < NQ; q++)
            assert (!(i_credit_return[q] && !o_pop[q] && credit_q[q] == CW'(CREDIT_MAX)));
      end
   end
`endif
`else
   localparam int unsigned unused_credit_max = CREDIT_MAX;
   logic unused_credit;

   assign credit_ok     = '1;
   assign unused_credit = ^i_credit_return;
`endif

   assign grant_ext = OPOW'(i_grant);

   always_comb begin
      for (int unsigned q = 0; q < NQ; q++)
         elig[q] = i_head_valid[q] & credit_ok[q] & grant_ext[i_head_dest[q]];
   end

   for (genvar p = 0; p < prio_num; p++) begin : g_pick
      exa_iarb_vc_rr_pick #(.vc_num(vc_num)) u_pick (
         .req_i   (elig[p*vc_num +: vc_num]),
         .ptr_i   (ptr_q[p]),
         .valid_o (pick_valid[p]),
         .idx_o   (pick_vc[p])
      );
   end

   always_comb begin
      logic        win_found;
      int unsigned win_p;
      logic [PW-1:0] win_vc;
      logic        pop_now;
      state_d   = state_q;
      q_sel_d   = q_sel_q;
      out_sel_d = out_sel_q;
      ptr_d     = ptr_q;
      o_request = '0;
      o_cts     = '0;
      o_pop     = '0;
      o_last    = 1'b0;
      win_found = 1'b0;
      win_p     = 0;
      win_vc    = '0;
      pop_now   = 1'b0;
      case (state_q)
         IDLE: begin
            for (int unsigned q = 0; q < NQ; q++)
               if (i_head_valid[q] && credit_ok[q]) o_request[i_head_dest[q]][q] = 1'b1;
            // Ascending scan lets the highest priority level overwrite lower ones.
            for (int unsigned p = 0; p < prio_num; p++) begin
               if (pick_valid[p]) begin
                  win_found = 1'b1;
                  win_p     = p;
                  win_vc    = pick_vc[p];
               end
            end
            if (win_found) begin
               state_d        = STREAM;
               q_sel_d        = QW'(qidx(win_p, 32'(win_vc), vc_num));
               out_sel_d      = i_head_dest[q_sel_d];
               ptr_d[win_p]   = (32'(win_vc) == vc_num - 1) ? '0 : PW'(32'(win_vc) + 1);
            end
         end
         STREAM: begin
            o_cts[out_sel_q] = 1'b1;
            pop_now          = i_head_valid[q_sel_q] & credit_ok[q_sel_q];
            o_pop[q_sel_q]   = pop_now;
            o_last           = pop_now & i_head_last[q_sel_q];
            if (o_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         q_sel_q   <= '0;
         out_sel_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         q_sel_q   <= q_sel_d;
         out_sel_q <= out_sel_d;
         ptr_q     <= ptr_d;
      end
   end

   assign o_out_sel = out_sel_q;
   assign o_busy    = (state_q == STREAM);

endmodule
